// File: rtl/arrow_board_ctrl.sv
// Arrow board sequencing controller: phase timebase, frame-deferred
// configuration, lamp-test and blanking controls for the lamp decoder.
module arrow_board_ctrl #(
    parameter int PRESCALE = 1000,
    parameter int LT_STEPS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hold,
    input  logic [7:0] step_div,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [7:0] cfg_data,
    output logic [1:0] phase,
    output logic [3:0] pattern,
    output logic       flashing,
    output logic       sequential,
    output logic       lt,
    output logic       bi,
    output logic       frame_start
);

    localparam int PW =
        (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX =
        PW'(PRESCALE - 1);
    localparam logic [3:0] LTN = 4'(LT_STEPS);

    typedef struct packed {
        logic       blank;
        logic       seq;
        logic       flash;
        logic [3:0] pat;
    } cfg_t;

    logic [PW-1:0] pcnt;
    logic [7:0]    scnt;
    logic [3:0]    ltcnt;
    logic          pending;
    logic          configured;
    cfg_t          pend;

    logic tick;
    logic step;
    logic boundary;
    logic accept;
    logic first;
    logic lt_req;

    assign cfg_ready = ~pending;
    assign accept    = cfg_valid & cfg_ready;
    assign first     = accept & ~configured;
    assign lt_req    = accept & cfg_data[6];
    assign tick      = ~hold & (pcnt == PMAX);
    assign step      = tick & (scnt >= step_div);
    assign boundary  = step & (phase == 2'd3);

    // First configuration restarts the timebase so the
    // animation starts cleanly from phase 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt        <= '0;
            scnt        <= '0;
            phase       <= '0;
            frame_start <= 1'b0;
        end else if (first) begin
            pcnt        <= '0;
            scnt        <= '0;
            phase       <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= boundary;
            if (!hold) begin
                if (tick) pcnt <= '0;
                else      pcnt <= pcnt + PW'(1);
            end
            if (tick) begin
                if (step) scnt <= '0;
                else      scnt <= scnt + 8'd1;
            end
            if (step) phase <= phase + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern    <= '0;
            flashing   <= 1'b0;
            sequential <= 1'b0;
            bi         <= 1'b0;
            pending    <= 1'b0;
            pend       <= '0;
            configured <= 1'b0;
        end else if (first) begin
            pattern    <= cfg_data[3:0];
            flashing   <= cfg_data[4];
            sequential <= cfg_data[5];
            bi         <= ~cfg_data[7];
            configured <= 1'b1;
        end else if (boundary && pending) begin
            pattern    <= pend.pat;
            flashing   <= pend.flash;
            sequential <= pend.seq;
            bi         <= ~pend.blank;
            pending    <= 1'b0;
        end else if (accept) begin
            pend.pat   <= cfg_data[3:0];
            pend.flash <= cfg_data[4];
            pend.seq   <= cfg_data[5];
            pend.blank <= cfg_data[7];
            pending    <= 1'b1;
        end
    end

    // A fresh request reloads even when a step lands on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lt    <= 1'b1;
            ltcnt <= '0;
        end else if (lt_req) begin
            lt    <= 1'b0;
            ltcnt <= LTN;
        end else if (step && ltcnt != 4'd0) begin
            ltcnt <= ltcnt - 4'd1;
            if (ltcnt == 4'd1) lt <= 1'b1;
        end
    end

endmodule

// File: tb/tb_arrow_board_ctrl.sv
// Scoreboard bench for arrow_board_ctrl with PRESCALE=1, LT_STEPS=4.
// Vector order: {phase,pattern,flashing,sequential,lt,bi,frame_start,cfg_ready}.
module tb_arrow_board_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       hold;
    logic [7:0] step_div;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_data;
    logic [1:0] phase;
    logic [3:0] pattern;
    logic       flashing;
    logic       sequential;
    logic       lt;
    logic       bi;
    logic       frame_start;

    int n_chk = 0;
    int n_fail = 0;

    logic [11:0] sb[$];
    string       tg[$];
    logic [11:0] got;
    logic [11:0] want;
    string       tag;

    arrow_board_ctrl #(
        .PRESCALE(1),
        .LT_STEPS(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hold       (hold),
        .step_div   (step_div),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_data   (cfg_data),
        .phase      (phase),
        .pattern    (pattern),
        .flashing   (flashing),
        .sequential (sequential),
        .lt         (lt),
        .bi         (bi),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] mk(
        input logic [1:0] ph, input logic [3:0] pat,
        input logic fl, input logic sq, input logic l,
        input logic b, input logic fs, input logic rdy);
        return {ph, pat, fl, sq, l, b, fs, rdy};
    endfunction

    function automatic logic [11:0] snap();
        return {phase, pattern, flashing, sequential,
                lt, bi, frame_start, cfg_ready};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [7:0] sd);
        rst_n     = 1'b0;
        hold      = 1'b0;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        step_div  = sd;
        cyc();
    endtask

    task automatic test_reset();
        do_reset(8'd1);
        sb.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
        tg.push_back("reset_values");
        got = snap(); want = sb.pop_front(); tag = tg.pop_front();
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            sb.push_back(mk(2'((k >> 1) & 3), 0, 0, 0, 1, 0,
                            (k % 8) == 0, 1));
            tg.push_back($sformatf("free_run_%0d", k));
            cyc();
            got = snap(); want = sb.pop_front(); tag = tg.pop_front();
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", tag, got, want);
            end
        end
    endtask

    task automatic test_first_config();
        do_reset(8'd1);
        rst_n = 1'b1;
        repeat (3) cyc();
        cfg_valid = 1'b1;
        cfg_data  = 8'h15;
        sb.push_back(mk(0, 5, 1, 0, 1, 1, 0, 1));
        sb.push_back(mk(0, 5, 1, 0, 1, 1, 0, 1));
        sb.push_back(mk(1, 5, 1, 0, 1, 1, 0, 1));
        for (int i = 0; i < 3; i++) begin
            tg.push_back($sformatf("first_cfg_%0d", i));
            cyc();
            cfg_valid = 1'b0;
            got = snap(); want = sb.pop_front(); tag = tg.pop_front();
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", tag, got, want);
            end
        end
    endtask

    task automatic test_deferred();
        logic [11:0] ex[7];
        ex = '{mk(1, 5, 1, 0, 1, 1, 0, 0),
               mk(2, 5, 1, 0, 1, 1, 0, 0),
               mk(2, 5, 1, 0, 1, 1, 0, 0),
               mk(3, 5, 1, 0, 1, 1, 0, 0),
               mk(3, 5, 1, 0, 1, 1, 0, 0),
               mk(0, 4'hA, 0, 1, 1, 1, 1, 1),
               mk(0, 4'hA, 0, 1, 1, 1, 0, 1)};
        do_reset(8'd1);
        rst_n     = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'h15;
        cyc();
        cfg_valid = 1'b0;
        repeat (2) cyc();
        cfg_valid = 1'b1;
        cfg_data  = 8'h2A;
        for (int i = 0; i < 7; i++) begin
            sb.push_back(ex[i]);
            tg.push_back($sformatf("deferred_%0d", i));
            cyc();
            cfg_valid = 1'b0;
            got = snap(); want = sb.pop_front(); tag = tg.pop_front();
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", tag, got, want);
            end
        end
    endtask

    task automatic test_lamp_test();
        logic [11:0] ex[14];
        ex = '{mk(0, 0, 0, 0, 0, 1, 0, 1),
               mk(1, 0, 0, 0, 0, 1, 0, 1),
               mk(2, 0, 0, 0, 0, 1, 0, 1),
               mk(3, 0, 0, 0, 0, 1, 0, 0),
               mk(0, 0, 0, 0, 0, 1, 1, 1),
               mk(1, 0, 0, 0, 0, 1, 0, 1),
               mk(2, 0, 0, 0, 0, 1, 0, 1),
               mk(3, 0, 0, 0, 1, 1, 0, 1),
               mk(0, 0, 0, 0, 1, 1, 1, 1),
               mk(1, 0, 0, 0, 0, 1, 0, 0),
               mk(2, 0, 0, 0, 0, 1, 0, 0),
               mk(3, 0, 0, 0, 0, 1, 0, 0),
               mk(0, 0, 0, 0, 0, 1, 1, 1),
               mk(1, 0, 0, 0, 1, 1, 0, 1)};
        do_reset(8'd0);
        rst_n = 1'b1;
        cyc();
        cfg_valid = 1'b1;
        cfg_data  = 8'h40;
        for (int i = 0; i < 14; i++) begin
            sb.push_back(ex[i]);
            tg.push_back($sformatf("lamp_test_%0d", i));
            cyc();
            got = snap(); want = sb.pop_front(); tag = tg.pop_front();
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", tag, got, want);
            end
            cfg_valid = (i == 2) || (i == 8);
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_hold();
        do_reset(8'd1);
        rst_n     = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'h15;
        cyc();
        cfg_valid = 1'b0;
        for (int i = 0; i < 18; i++) begin
            if (i == 3) sb.push_back(mk(2, 5, 1, 0, 1, 1, 0, 1));
            else if (i < 3) begin
                cyc();
                continue;
            end else if (i < 16)
                sb.push_back(mk(2'((i >= 15) ? 3 : 2), 5, 1, 0,
                                1, 1, 0, 0));
            else if (i == 16)
                sb.push_back(mk(3, 5, 1, 0, 1, 1, 0, 0));
            else
                sb.push_back(mk(0, 4'hA, 0, 1, 1, 1, 1, 1));
            tg.push_back($sformatf("hold_%0d", i));
            cyc();
            got = snap(); want = sb.pop_front(); tag = tg.pop_front();
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", tag, got, want);
            end
            if (i == 3) begin
                hold      = 1'b1;
                cfg_valid = 1'b1;
                cfg_data  = 8'h2A;
            end else begin
                cfg_valid = 1'b0;
            end
            if (i == 13) hold = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] ex[9];
        ex = '{mk(0, 5, 1, 0, 1, 1, 0, 1),
               mk(1, 5, 1, 0, 1, 1, 0, 0),
               mk(2, 5, 1, 0, 1, 1, 0, 0),
               mk(3, 5, 1, 0, 1, 1, 0, 0),
               mk(0, 4'hA, 0, 1, 1, 1, 1, 1),
               mk(1, 4'hA, 0, 1, 1, 1, 0, 0),
               mk(2, 4'hA, 0, 1, 1, 1, 0, 0),
               mk(3, 4'hA, 0, 1, 1, 1, 0, 0),
               mk(0, 4'hB, 1, 1, 1, 1, 1, 1)};
        do_reset(8'd0);
        rst_n     = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'h15;
        for (int i = 0; i < 9; i++) begin
            sb.push_back(ex[i]);
            tg.push_back($sformatf("back_to_back_%0d", i));
            cyc();
            got = snap(); want = sb.pop_front(); tag = tg.pop_front();
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", tag, got, want);
            end
            if (i == 0) cfg_data = 8'h2A;
            if (i == 1) cfg_data = 8'h3B;
            if (i == 5) cfg_valid = 1'b0;
        end
    endtask

    task automatic test_reset_pending();
        do_reset(8'd1);
        rst_n     = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = 8'h15;
        cyc();
        cfg_valid = 1'b0;
        repeat (2) cyc();
        cfg_valid = 1'b1;
        cfg_data  = 8'h2A;
        sb.push_back(mk(1, 5, 1, 0, 1, 1, 0, 0));
        tg.push_back("rst_pend_accepted");
        cyc();
        cfg_valid = 1'b0;
        got = snap(); want = sb.pop_front(); tag = tg.pop_front();
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
        #2;
        rst_n = 1'b0;
        sb.push_back(mk(0, 0, 0, 0, 1, 0, 0, 1));
        tg.push_back("rst_async");
        #1;
        got = snap(); want = sb.pop_front(); tag = tg.pop_front();
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
        cyc();
        rst_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            if (k <= 10)
                sb.push_back(mk(2'((k >> 1) & 3), 0, 0, 0, 1, 0,
                                k == 8, 1));
            else
                sb.push_back(mk(0, 4'hA, 0, 1, 1, 1, 0, 1));
            tg.push_back($sformatf("rst_after_%0d", k));
            cyc();
            cfg_valid = 1'b0;
            got = snap(); want = sb.pop_front(); tag = tg.pop_front();
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL %s: got %h expected %h", tag, got, want);
            end
            if (k == 10) begin
                cfg_valid = 1'b1;
                cfg_data  = 8'h2A;
            end
        end
        cfg_valid = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        hold      = 1'b0;
        step_div  = 8'd1;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        #2;
        test_reset();
        test_first_config();
        test_deferred();
        test_lamp_test();
        test_hold();
        test_back_to_back();
        test_reset_pending();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
